// File: rtl/mix_pkg.sv
// mix_pkg: shared types and width helpers for the mix_scheduler slice.
//   mix_state_t : scheduler FSM states (IDLE, ACCUM, PRESENT)
//   acc_w()     : accumulator width for a given output width (one guard bit)
//   idx_w()     : channel index width, never below 1 bit
package mix_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PRESENT = 2'd2
  } mix_state_t;

  // One extra bit above the audio width lets the saturation test see a sum
  // that has gone past the largest representable sample.
  function automatic int acc_w(input int out_w);
    return out_w + 1;
  endfunction

  function automatic int idx_w(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/sat_accum.sv
// sat_accum: registered accumulator with synchronous clear, conditional add
// and a saturating view of the value it will hold after this cycle's add.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : zero the accumulator on the next edge
//   add_en    : add addend on the next edge
//   addend    : zero-extended operand, W bits
//   sat_next  : next accumulator value clamped to OUT_W bits (all ones on excess)
module sat_accum #(
  parameter int OUT_W = 12,
  parameter int W     = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add_en,
  input  logic [W-1:0]     addend,
  output logic [OUT_W-1:0] sat_next
);

  logic [W-1:0] acc_q;
  logic [W-1:0] addend_g;
  logic [W:0]   raw;
  logic [W-1:0] acc_next;

  always_comb begin
    addend_g = add_en ? addend : '0;
    raw      = {1'b0, acc_q} + {1'b0, addend_g};
    // Pin at all ones on carry-out so the accumulator itself never wraps.
    acc_next = raw[W] ? '1 : raw[W-1:0];
    sat_next = (|acc_next[W-1:OUT_W]) ? '1 : acc_next[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (add_en) begin
      acc_q <= acc_next;
    end
  end

endmodule

// File: rtl/mix_scheduler.sv
// mix_scheduler: snapshots NUM channels on sample_tick, sums the enabled ones
// through one shared saturating adder (one channel per clock), then presents
// the sample downstream.
// Handshake: audio_valid rises with a new sample and audio stays stable until
// a cycle with audio_valid=1 and audio_ready=1; that cycle transfers the sample
// and audio_valid drops on the following edge. audio keeps its last value.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   sample_tick   : one-cycle sample period start
//   channels      : packed unsigned samples, channel i = [i*N +: N]
//   ch_enable     : per-channel enable
//   audio_ready   : downstream accept
//   audio         : mixed, saturated sample
//   audio_valid   : audio holds an unaccepted sample
//   busy          : FSM not in IDLE
//   overrun       : sticky, a tick arrived when it could not be accepted
//   overrun_clr   : synchronous clear for overrun (a same-cycle drop wins)
module mix_scheduler
  import mix_pkg::*;
#(
  parameter int NUM   = 4,
  parameter int N     = 4,
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_tick,
  input  logic [NUM*N-1:0] channels,
  input  logic [NUM-1:0]   ch_enable,
  input  logic             audio_ready,
  output logic [OUT_W-1:0] audio,
  output logic             audio_valid,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int ACC_W = acc_w(OUT_W);
  localparam int IDX_W = idx_w(NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  if (OUT_W < N + $clog2(NUM)) begin : g_width_check
    $error("mix_scheduler: OUT_W too narrow for NUM channels of N bits");
  end

  mix_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [NUM*N-1:0] snap_ch;
  logic [NUM-1:0]   snap_en;

  logic             handshake;
  logic             start;
  logic             drop;
  logic             add_en;
  logic [ACC_W-1:0] addend;
  logic [OUT_W-1:0] sat_next;

  always_comb begin
    handshake = (state == PRESENT) && audio_valid && audio_ready;
    // A tick is taken when idle, or when the held sample leaves this cycle.
    start     = sample_tick && ((state == IDLE) || handshake);
    drop      = sample_tick && !start;
    add_en    = (state == ACCUM);
    addend    = snap_en[idx] ? ACC_W'(snap_ch[idx*N +: N]) : '0;
  end

  sat_accum #(
    .OUT_W (OUT_W),
    .W     (ACC_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .add_en   (add_en),
    .addend   (addend),
    .sat_next (sat_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      snap_ch     <= '0;
      snap_en     <= '0;
      audio       <= '0;
      audio_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            snap_ch <= channels;
            snap_en <= ch_enable;
            idx     <= '0;
            state   <= ACCUM;
            busy    <= 1'b1;
          end
        end
        ACCUM: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            idx         <= '0;
            audio       <= sat_next;
            audio_valid <= 1'b1;
            state       <= PRESENT;
          end
        end
        PRESENT: begin
          if (handshake) begin
            audio_valid <= 1'b0;
            if (start) begin
              snap_ch <= channels;
              snap_en <= ch_enable;
              idx     <= '0;
              state   <= ACCUM;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          audio_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mix_scheduler.md
Name: mix_scheduler

Overview:
- Sequences mixing of NUM N-bit oscillator channels into one OUT_W-bit audio sample per sample period.
- Uses a single time-shared adder rather than a full combinational adder tree.
- Sits between the per-channel wave generators and the DAC/PWM output stage.
- Snapshots all channels on each sample tick, accumulates enabled channels one per clock, then offers the result downstream on a valid/ready handshake.

Parameters:
- NUM, 4, number of channels.
- N, 4, bits per channel.
- OUT_W, 12, audio sample width; elaboration error if OUT_W < N + $clog2(NUM).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- sample_tick  input  1  one-cycle pulse marking the start of a sample period.
- channels  input  NUM*N  packed channel samples; channel i is bits [i*N +: N].
- ch_enable  input  NUM  per-channel enable; 0 excludes that channel from the sum.
- audio_ready  input  1  downstream accepts the sample.
- audio  output  OUT_W  mixed sample.
- audio_valid  output  1  audio holds a new, unaccepted sample.
- busy  output  1  high in any state other than IDLE.
- overrun  output  1  sticky flag: a tick arrived while the block could not accept it.
- overrun_clr  input  1  synchronous clear for overrun.

Behaviour:
- Reset values (async on rst): state=IDLE, audio=0, audio_valid=0, busy=0, overrun=0, accumulator=0, index=0, snapshot regs=0.
- FSM states: IDLE, ACCUM, PRESENT.
- IDLE:
  - sample_tick=1 → latch channels and ch_enable into snapshot regs, clear accumulator, index=0, go to ACCUM.
- ACCUM:
  - Each cycle: accumulator += snapshot[index] if enable_snap[index], else += 0.
  - Increment index; after the index=NUM-1 add, go to PRESENT.
  - On that same edge load audio from the accumulator and set audio_valid=1.
- PRESENT:
  - audio and audio_valid held stable while audio_ready=0.
  - audio_valid=1 and audio_ready=1 → handshake complete; audio_valid clears next edge.
  - If sample_tick=1 in the same cycle as the handshake, start the new capture directly (go to ACCUM); otherwise go to IDLE.
  - audio keeps its last value after the handshake.
- Latency: tick accepted at edge k → audio_valid=1 after edge k+NUM (NUM ACCUM cycles). Minimum sample period NUM+1 cycles with audio_ready tied high.
- Snapshot rule: changes on channels/ch_enable after the capture edge have no effect on the current sample.
- Arithmetic:
  - Channels are unsigned and zero-extended to the accumulator width (OUT_W+1 bits).
  - If the sum exceeds 2^OUT_W-1, audio saturates to all ones.
  - Never wraps.
- Overrun:
  - sample_tick=1 in ACCUM, or in PRESENT without a same-cycle handshake, is dropped and sets overrun=1.
  - overrun_clr=1 clears overrun; if overrun_clr and a dropping tick occur in the same cycle, set wins.
- busy = (state != IDLE).
- Reset mid-operation: every register returns to its reset value immediately. No partial sample is ever presented; the first tick after reset release starts cleanly.

Decomposition:
- mix_pkg holds:
  - mix_state_t enum {IDLE, ACCUM, PRESENT}.
  - Accumulator-width helper function acc_w(OUT_W).
  - Index-width localparam derivation ($clog2(NUM), minimum 1).
- Sub-module sat_accum (width parameter): registered accumulator with clear, conditional add and saturating output. Keeps the FSM file to control only.

Test Plan (NUM=4, N=4, OUT_W=12, audio_ready=1 unless noted):
- Reset/all-zero: after reset, check audio=0, audio_valid=0, busy=0, overrun=0. channels=0x0000, ch_enable=4'hF, tick → audio=0 with audio_valid high exactly 4 cycles after the tick edge.
- Summation: channels=0x8421, ch_enable=4'hF, tick → audio=15. Then ch_enable=4'b0101 → audio=5. Then channels=0xFFFF, ch_enable=4'hF → audio=60.
- Snapshot: channels=0x0001, tick; change channels to 0xFFFF one cycle later → audio=1.
- Backpressure/overrun:
  - audio_ready=0 for 10 cycles after valid: audio=15 and audio_valid stay stable throughout.
  - Tick during the stall → overrun=1, no new sample produced.
  - overrun_clr pulse → overrun=0.
  - Tick in the same cycle as a handshake → next sample is produced with no overrun.
- Reset mid-ACCUM: assert rst two cycles after a tick → audio=0, audio_valid=0, busy=0 immediately. After release, a tick with 0x8421 gives audio=15.
- Saturation (OUT_W=5 build, NUM=2, N=4): channels=0xFF → audio=30, no wrap. Check at the 31 boundary with a forced accumulator or an OUT_W=4 negative elaboration check.
